seg_serial_driver: RTL and testbench

- Downstream consumer of the 64-bit per-digit segment pattern bus (8 digits × {a,b,c,d,e,f,g,p}) produced by the hex-to-segment stage.
- Captures a frame on request and shifts it out over the board's serial 7-segment interface (cascaded 74HC164-style shift registers): serial clock, serial data, blanking enable.
- Sits between the display-formatting logic and the top-level board pins.

---
 rtl/seg_serial_driver_pkg.sv | 16 +
 rtl/seg_serial_driver_if.sv | 12 +
 rtl/seg_serial_driver_clk_div.sv | 33 +++
 rtl/seg_serial_driver.sv | 135 +++++++++++++
 tb/tb_seg_serial_driver.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/seg_serial_driver_pkg.sv
// Shared display constants and the serial driver state encoding.
package seg_serial_driver_pkg;

    localparam int SEG_DIGITS   = 8;
    localparam int SEG_BITS     = 8;
    localparam int SEG_DATA_W   = SEG_DIGITS * SEG_BITS;
    localparam int SEG_HALF_DIV = 4;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        HIGH,
        DONE
    } seg_state_t;

endpackage

// File: rtl/seg_serial_driver_if.sv
// Frame request handshake between the display formatter and the serial driver.
interface seg_serial_driver_if #(
    parameter int DATA_W = 64
);
    logic              start;
    logic [DATA_W-1:0] par_data;
    logic              busy;
    logic              done;

    modport master (output start, output par_data, input busy, input done);
    modport slave  (input start, input par_data, output busy, output done);
endinterface

// File: rtl/seg_serial_driver_clk_div.sv
// Half-period tick generator: one-cycle registered tick every HALF_DIV enabled cycles.
module seg_clk_div #(
    parameter int HALF_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);
    localparam int CNT_W = $clog2(HALF_DIV) + 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(HALF_DIV - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (en) begin
            if (cnt == LAST) begin
                cnt  <= '0;
                tick <= 1'b1;
            end else begin
                cnt  <= cnt + 1'b1;
                tick <= 1'b0;
            end
        end else begin
            tick <= 1'b0;
        end
    end

endmodule

// File: rtl/seg_serial_driver.sv
// Serial 7-segment frame driver (MSB first into cascaded 74HC164s).
// Optional SEG_AUTO_REFRESH_EN: resend automatically whenever par_data changes.
module seg_serial_driver
    import seg_serial_driver_pkg::*;
#(
    parameter int DATA_W   = SEG_DATA_W,
    parameter int HALF_DIV = SEG_HALF_DIV
) (
    input  logic               clk,
    input  logic               rst,
    seg_serial_driver_if.slave bus,
    output logic               seg_clk,
    output logic               seg_dat,
    output logic               seg_en
);
    localparam int BIT_W = $clog2(DATA_W);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);

    seg_state_t        state, state_nxt;
    logic [DATA_W-1:0] shreg, shreg_nxt;
    logic [BIT_W-1:0]  bit_cnt, bit_cnt_nxt;
    logic              busy_r, busy_nxt;
    logic              clk_nxt, dat_nxt, en_nxt;
    logic              div_en, div_clr, tick;
    logic              go;

    // The divider tick is registered, so the first SETUP phase runs one
    // cycle longer than HALF_DIV; every later phase is exactly HALF_DIV.
    seg_clk_div #(.HALF_DIV(HALF_DIV)) u_div (
        .clk  (clk),
        .rst  (rst),
        .en   (div_en),
        .clr  (div_clr),
        .tick (tick)
    );

`ifdef SEG_AUTO_REFRESH_EN
    logic [DATA_W-1:0] last_frame;
    logic              sent;
    logic              accept;

    assign go     = bus.start || !sent || (bus.par_data != last_frame);
    assign accept = (state == IDLE) && go;

    always_ff @(posedge clk) begin
        if (rst) begin
            last_frame <= '0;
            sent       <= 1'b0;
        end else if (accept) begin
            last_frame <= bus.par_data;
            sent       <= 1'b1;
        end
    end
`else
    assign go = bus.start;
`endif

    assign bus.busy = busy_r;
    assign bus.done = (state == DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            shreg   <= '0;
            bit_cnt <= '0;
            busy_r  <= 1'b0;
            seg_clk <= 1'b0;
            seg_dat <= 1'b0;
            seg_en  <= 1'b0;
        end else begin
            state   <= state_nxt;
            shreg   <= shreg_nxt;
            bit_cnt <= bit_cnt_nxt;
            busy_r  <= busy_nxt;
            seg_clk <= clk_nxt;
            seg_dat <= dat_nxt;
            seg_en  <= en_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        shreg_nxt   = shreg;
        bit_cnt_nxt = bit_cnt;
        busy_nxt    = busy_r;
        clk_nxt     = seg_clk;
        dat_nxt     = seg_dat;
        en_nxt      = seg_en;
        div_en      = 1'b0;
        div_clr     = 1'b0;
        case (state)
            IDLE: begin
                clk_nxt = 1'b0;
                if (go) begin
                    shreg_nxt   = bus.par_data;
                    bit_cnt_nxt = '0;
                    busy_nxt    = 1'b1;
                    en_nxt      = 1'b0;
                    dat_nxt     = bus.par_data[DATA_W-1];
                    div_clr     = 1'b1;
                    state_nxt   = SETUP;
                end
            end
            SETUP: begin
                div_en = 1'b1;
                if (tick) begin
                    clk_nxt   = 1'b1;
                    state_nxt = HIGH;
                end
            end
            HIGH: begin
                div_en = 1'b1;
                if (tick) begin
                    clk_nxt = 1'b0;
                    if (bit_cnt == LAST_BIT) begin
                        state_nxt = DONE;
                    end else begin
                        shreg_nxt   = shreg << 1;
                        bit_cnt_nxt = bit_cnt + 1'b1;
                        dat_nxt     = shreg[DATA_W-2];
                        state_nxt   = SETUP;
                    end
                end
            end
            DONE: begin
                busy_nxt  = 1'b0;
                en_nxt    = 1'b1;
                dat_nxt   = 1'b0;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_seg_serial_driver.sv
// Bench for seg_serial_driver: bit scoreboard on seg_clk rising edges plus frame vectors.
module tb_seg_serial_driver;

    localparam int DW        = 64;
    localparam int HD        = 2;
    localparam int FRAME_LAT = 2 * HD * DW + 1;

    logic clk = 1'b0;
    logic rst;
    logic seg_clk, seg_dat, seg_en;

    seg_serial_driver_if #(.DATA_W(DW)) bus ();

    seg_serial_driver #(.DATA_W(DW), .HALF_DIV(HD)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .seg_clk (seg_clk),
        .seg_dat (seg_dat),
        .seg_en  (seg_en)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] data;
        int          lat;
        int          edges;
        logic        en_after;
    } vec_t;

    vec_t vecs[5];

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    logic exp_q[$];
    int   rises = 0;
    int   done_cnt = 0;
    int   done_cyc = 0;
    int   acc_cyc  = 0;
    logic prev_clk = 1'b0, prev_dat = 1'b0, prev_done = 1'b0;
    int   lat, r0, r1, d0, d1cyc;
    bit   ok;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: act=%0h req=%0h (cyc %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: every rising seg_clk consumes one expected bit.
    always @(negedge clk) begin
        if (seg_clk === 1'b1 && prev_clk === 1'b0) begin
            rises++;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_edge: act=edge req=none (cyc %0d)", cyc);
            end else begin
                check("bit", 64'(seg_dat), 64'(exp_q.pop_front()));
                check("en_low_in_frame", 64'(seg_en), 64'd0);
            end
        end
        if (seg_clk === 1'b1 && prev_clk === 1'b1)
            check("dat_hold", 64'(seg_dat), 64'(prev_dat));
        if (bus.done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
            check("done_width", 64'(prev_done), 64'd0);
        end
        prev_clk  = seg_clk;
        prev_dat  = seg_dat;
        prev_done = bus.done;
    end

    task automatic push_frame(input logic [63:0] d);
        for (int i = DW - 1; i >= 0; i--) exp_q.push_back(d[i]);
    endtask

    task automatic start_frame(input logic [63:0] d);
        bus.par_data = d;
        bus.start    = 1'b1;
        push_frame(d);
        @(negedge clk);
        bus.start = 1'b0;
        acc_cyc   = cyc;
        check("busy_on_accept", 64'(bus.busy), 64'd1);
    endtask

    task automatic wait_done(input int budget, output int l);
        int  base = done_cnt;
        bit  seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            if (done_cnt != base) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            total++;
            bad++;
            $display("FAIL done_timeout: act=no_done req=done within %0d cycles", budget);
        end
        l = done_cyc - acc_cyc;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"},    64'(bus.busy), 64'd0);
        check({tag, "_done"},    64'(bus.done), 64'd0);
        check({tag, "_seg_clk"}, 64'(seg_clk),  64'd0);
        check({tag, "_seg_dat"}, 64'(seg_dat),  64'd0);
        check({tag, "_seg_en"},  64'(seg_en),   64'd0);
    endtask

    initial begin
        vecs[0] = '{64'hA5A5_0000_FFFF_0123, FRAME_LAT, DW, 1'b1};
        vecs[1] = '{64'h0000_0000_0000_0000, FRAME_LAT, DW, 1'b1};
        vecs[2] = '{64'hFFFF_FFFF_FFFF_FFFF, FRAME_LAT, DW, 1'b1};
        vecs[3] = '{64'h8000_0000_0000_0001, FRAME_LAT, DW, 1'b1};
        vecs[4] = '{{$urandom, $urandom},    FRAME_LAT, DW, 1'b1};

        rst = 1'b1;
`ifdef SEG_AUTO_REFRESH_EN
        bus.start    = 1'b0;
        bus.par_data = '0;
`else
        bus.start    = 1'b1;
        bus.par_data = 64'hFFFF_FFFF_FFFF_FFFF;
`endif
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");

`ifdef SEG_AUTO_REFRESH_EN
        // Zero frame goes out on its own after reset.
        push_frame(64'h0);
        rst = 1'b0;
        @(negedge clk);
        acc_cyc = cyc;
        check("auto_first_busy", 64'(bus.busy), 64'd1);
        wait_done(2 * FRAME_LAT, lat);
        @(negedge clk);
        check("auto_first_lat", 64'(lat), 64'(FRAME_LAT));
        check("auto_first_en", 64'(seg_en), 64'd1);

        bus.par_data = 64'hFF;
        push_frame(64'hFF);
        @(negedge clk);
        acc_cyc = cyc;
        check("auto_change_busy", 64'(bus.busy), 64'd1);
        wait_done(2 * FRAME_LAT, lat);
        @(negedge clk);
        check("auto_change_lat", 64'(lat), 64'(FRAME_LAT));

        d0 = done_cnt;
        r0 = rises;
        repeat (1000) @(negedge clk);
        check("auto_stable_done", 64'(done_cnt - d0), 64'd0);
        check("auto_stable_edges", 64'(rises - r0), 64'd0);
        check("auto_stable_busy", 64'(bus.busy), 64'd0);

        start_frame(64'hFF);
        wait_done(2 * FRAME_LAT, lat);
        @(negedge clk);
        check("auto_start_lat", 64'(lat), 64'(FRAME_LAT));
        check("auto_start_q", 64'(exp_q.size()), 64'd0);
`else
        rst       = 1'b0;
        bus.start = 1'b0;
        r0 = rises;
        repeat (20) @(negedge clk);
        check("idle_edges", 64'(rises - r0), 64'd0);
        check("idle_busy", 64'(bus.busy), 64'd0);

        for (int v = 0; v < 5; v++) begin
            r0 = rises;
            start_frame(vecs[v].data);
            wait_done(2 * FRAME_LAT, lat);
            @(negedge clk);
            check("vec_latency", 64'(lat), 64'(vecs[v].lat));
            check("vec_edges", 64'(rises - r0), 64'(vecs[v].edges));
            check("vec_en_after", 64'(seg_en), 64'(vecs[v].en_after));
            check("vec_busy_after", 64'(bus.busy), 64'd0);
            check("vec_q_empty", 64'(exp_q.size()), 64'd0);
        end

        // Starts mid-frame are ignored and par_data changes are not seen.
        r0 = rises;
        d0 = done_cnt;
        start_frame(64'hC3C3_1234_5678_9ABC);
        repeat (9) @(negedge clk);
        bus.start    = 1'b1;
        bus.par_data = '0;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (89) @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(2 * FRAME_LAT, lat);
        @(negedge clk);
        check("ign_latency", 64'(lat), 64'(FRAME_LAT));
        repeat (300) @(negedge clk);
        check("ign_done_count", 64'(done_cnt - d0), 64'd1);
        check("ign_edges", 64'(rises - r0), 64'(DW));
        check("ign_q_empty", 64'(exp_q.size()), 64'd0);

        // start held high: next frame accepted on the IDLE cycle after DONE.
        d0 = done_cnt;
        bus.par_data = 64'h1;
        bus.start    = 1'b1;
        push_frame(64'h1);
        @(negedge clk);
        acc_cyc = cyc;
        check("b2b_busy1", 64'(bus.busy), 64'd1);
        bus.par_data = 64'h8000_0000_0000_0000;
        push_frame(64'h8000_0000_0000_0000);
        wait_done(2 * FRAME_LAT, lat);
        d1cyc = done_cyc;
        check("b2b_lat1", 64'(lat), 64'(FRAME_LAT));
        @(negedge clk);
        check("b2b_idle_gap", 64'(bus.busy), 64'd0);
        @(negedge clk);
        check("b2b_busy2", 64'(bus.busy), 64'd1);
        acc_cyc   = cyc;
        bus.start = 1'b0;
        wait_done(2 * FRAME_LAT, lat);
        @(negedge clk);
        check("b2b_lat2", 64'(lat), 64'(FRAME_LAT));
        check("b2b_done_gap", 64'(done_cyc - d1cyc), 64'(FRAME_LAT + 2));
        check("b2b_done_count", 64'(done_cnt - d0), 64'd2);
        check("b2b_q_empty", 64'(exp_q.size()), 64'd0);

        // Reset at bit 30 abandons the frame without a done pulse.
        r0 = rises;
        start_frame(64'hDEAD_BEEF_1234_5678);
        ok = 1'b0;
        for (int i = 0; i < 2 * FRAME_LAT; i++) begin
            @(posedge clk);
            if (rises - r0 >= 30) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL bit30_timeout: act=%0d edges req=30", rises - r0);
        end
        @(negedge clk);
        rst = 1'b1;
        d0  = done_cnt;
        @(posedge clk);
        exp_q.delete();
        @(negedge clk);
        check_reset_outputs("midrst");
        rst = 1'b0;
        r1  = rises;
        repeat (300) @(negedge clk);
        check("midrst_no_done", 64'(done_cnt - d0), 64'd0);
        check("midrst_no_edges", 64'(rises - r1), 64'd0);

        r0 = rises;
        start_frame(64'h0F0F_3C3C_5A5A_9669);
        wait_done(2 * FRAME_LAT, lat);
        @(negedge clk);
        check("after_rst_lat", 64'(lat), 64'(FRAME_LAT));
        check("after_rst_edges", 64'(rises - r0), 64'(DW));
        check("after_rst_en", 64'(seg_en), 64'd1);
`endif

        check("final_q_empty", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
